// File: rtl/md_pkg.sv
// Shared constants for the iterative multiply/divide unit:
// op encodings, FSM states and the fixed divide latency.
package md_pkg;

  localparam logic [2:0] MD_MULTU = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_DIVU  = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_MADDU = 3'b100;
  localparam logic [2:0] MD_MADD  = 3'b101;
  localparam logic [2:0] MD_MSUBU = 3'b110;
  localparam logic [2:0] MD_MSUB  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_t;

  // Start edge to commit edge: one bit per cycle plus sign fix-up.
  function automatic int md_div_lat(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/md_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes.
// Loads on start, then produces one quotient bit per cycle.
module md_div_iter
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             valid
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             run;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   trial;

  assign shl   = {rem, quo[WIDTH-1]};
  // Top bit set means the trial went negative: restore.
  assign trial = shl - {1'b0, dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      valid <= 1'b0;
    end else if (start) begin
      quo   <= dividend;
      rem   <= '0;
      dvs   <= divisor;
      cnt   <= CW'(WIDTH);
      run   <= 1'b1;
      valid <= 1'b0;
    end else if (abort) begin
      run   <= 1'b0;
      valid <= 1'b0;
    end else if (run) begin
      quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
      rem <= trial[WIDTH] ? shl[WIDTH-1:0]
                          : trial[WIDTH-1:0];
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        run   <= 1'b0;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/md_unit_iter.sv
// EX-stage multiply/divide unit owning HI/LO.
// Define MD_ACCUM_EN to build MADD/MADDU/MSUB/MSUBU.
module md_unit_iter
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic             Cancel,
  input  logic             We,
  input  logic             HiLo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  md_state_t        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic             q_neg;
  logic             r_neg;
  logic             dz_q;

  logic             is_div;
  logic             op_ok;
  logic             go;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic             div_valid;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  logic [2*WIDTH-1:0] ma;
  logic [2*WIDTH-1:0] mb;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mul_res;

  assign is_div = (Op == MD_DIVU) || (Op == MD_DIV);

`ifdef MD_ACCUM_EN
  logic acc_q;
  logic sub_q;

  assign op_ok = 1'b1;
`else
  assign op_ok = ~Op[2];
`endif

  assign go = Start && !Cancel && (state == ST_IDLE) && op_ok;

  assign Busy = (state != ST_IDLE);

  assign mag1 = (Op[0] && D1[WIDTH-1]) ? -D1 : D1;
  assign mag2 = (Op[0] && D2[WIDTH-1]) ? -D2 : D2;

  md_div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (Clk),
    .rst      (Rst),
    .start    (go && is_div),
    .abort    (Cancel),
    .dividend (mag1),
    .divisor  (mag2),
    .quo      (div_q),
    .rem      (div_r),
    .valid    (div_valid)
  );

  assign quo_fix = q_neg ? -div_q : div_q;
  assign rem_fix = r_neg ? -div_r : div_r;

  // Sign-extend to full width; the low 2*WIDTH bits are exact.
  assign ma   = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign mb   = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  assign prod = ma * mb;

`ifdef MD_ACCUM_EN
  assign mul_res = !acc_q ? prod
                 : sub_q  ? {HI, LO} - prod
                          : {HI, LO} + prod;
`else
  assign mul_res = prod;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dz_q    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      HI      <= '0;
      LO      <= '0;
`ifdef MD_ACCUM_EN
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (We && !Cancel) begin
            if (HiLo) HI <= D1;
            else      LO <= D1;
          end
          if (go) begin
            DivZero <= 1'b0;
            a_q     <= D1;
            b_q     <= D2;
            sgn_q   <= Op[0];
            q_neg   <= Op[0] & (D1[WIDTH-1] ^ D2[WIDTH-1]);
            r_neg   <= Op[0] & D1[WIDTH-1];
            dz_q    <= (D2 == '0);
`ifdef MD_ACCUM_EN
            acc_q   <= Op[2];
            sub_q   <= Op[1];
`endif
            if (is_div) begin
              state <= ST_DIV;
              cnt   <= CW'(md_div_lat(WIDTH) - 2);
            end else begin
              state <= ST_MUL;
              cnt   <= CW'(MUL_LAT - 1);
            end
          end
        end
        ST_MUL: begin
          if (Cancel) begin
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            {HI, LO} <= mul_res;
            Done     <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DIV: begin
          if (Cancel)          state <= ST_IDLE;
          else if (cnt == '0)  state <= ST_FIX;
          else                 cnt   <= cnt - 1'b1;
        end
        ST_FIX: begin
          state <= ST_IDLE;
          if (!Cancel && div_valid) begin
            // Zero divisor: quotient all ones, HI keeps raw dividend.
            if (dz_q) begin
              HI <= a_q;
              LO <= '1;
            end else begin
              HI <= rem_fix;
              LO <= quo_fix;
            end
            Done    <= 1'b1;
            DivZero <= dz_q;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_iter.sv
// Scoreboard bench for md_unit_iter: directed cases then random ops
// against an arithmetic reference model.
module tb_md_unit_iter;
  import md_pkg::*;

  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = md_div_lat(W);

`ifdef MD_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         Start = 1'b0;
  logic [2:0]   Op = 3'd0;
  logic [W-1:0] D1 = '0;
  logic [W-1:0] D2 = '0;
  logic         Cancel = 1'b0;
  logic         We = 1'b0;
  logic         HiLo = 1'b0;
  logic         Busy;
  logic         Done;
  logic         DivZero;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
    string        name;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [W-1:0] mh = '0;
  logic [W-1:0] ml = '0;
  logic         mdz = 1'b0;

  md_unit_iter #(
    .WIDTH   (W),
    .MUL_LAT (ML)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .Op      (Op),
    .D1      (D1),
    .D2      (D2),
    .Cancel  (Cancel),
    .We      (We),
    .HiLo    (HiLo),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural rules.
  function automatic exp_t model(input logic [2:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] xa, xb, p;
    int qa, qb;
    e.dz = 1'b0;
    e.cyc = 0;
    e.name = "";
    if (op == MD_DIVU || op == MD_DIV) begin
      if (b == '0) begin
        e.hi = a;
        e.lo = '1;
        e.dz = 1'b1;
      end else if (op == MD_DIVU) begin
        e.lo = a / b;
        e.hi = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.lo = a;
        e.hi = '0;
      end else begin
        qa = $signed(a);
        qb = $signed(b);
        e.lo = qa / qb;
        e.hi = qa % qb;
      end
    end else begin
      xa = op[0] ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
      xb = op[0] ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
      p = xa * xb;
      if (op[2]) p = op[1] ? {mh, ml} - p : {mh, ml} + p;
      {e.hi, e.lo} = p;
    end
    return e;
  endfunction

  always @(negedge Clk) begin
    exp_t e;
    if (Done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: Done=1 at cycle %0d with nothing pending", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_hi"}, HI, e.hi);
        chk({e.name, "_lo"}, LO, e.lo);
        chk({e.name, "_dz"}, DivZero, e.dz);
        chk({e.name, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  task automatic do_we(input bit hl, input logic [W-1:0] d);
    @(negedge Clk);
    We = 1'b1;
    HiLo = hl;
    D1 = d;
    @(negedge Clk);
    We = 1'b0;
    if (hl) mh = d;
    else    ml = d;
    chk("we_hi", HI, mh);
    chk("we_lo", LO, ml);
  endtask

  task automatic do_op(input string name, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit we, input bit hl);
    exp_t e;
    bit acc;
    int k;
    acc = !(op[2] && !ACC);
    @(negedge Clk);
    Start = 1'b1;
    Op = op;
    D1 = a;
    D2 = b;
    We = we;
    HiLo = hl;
    if (we) begin
      if (hl) mh = a;
      else    ml = a;
    end
    if (acc) begin
      e = model(op, a, b);
      e.name = name;
      e.cyc = cyc + 1 + ((op == MD_DIVU || op == MD_DIV) ? DL : ML);
      sb.push_back(e);
      mdz = 1'b0;
    end
    @(negedge Clk);
    Start = 1'b0;
    We = 1'b0;
    chk({name, "_busy"}, Busy, acc);
    chk({name, "_dz_clr"}, DivZero, mdz);
    if (acc) begin
      k = 0;
      while (Busy && k < 200) begin
        @(negedge Clk);
        k++;
      end
      chk({name, "_finish"}, Busy, 0);
      mh = e.hi;
      ml = e.lo;
      mdz = e.dz;
      @(negedge Clk);
      chk({name, "_done_pulse"}, Done, 0);
    end
    chk({name, "_hold_hi"}, HI, mh);
    chk({name, "_hold_lo"}, LO, ml);
    chk({name, "_sticky"}, DivZero, mdz);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] op;
    logic [W-1:0] a, b;
    int sel;

    repeat (2) @(negedge Clk);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_dz", DivZero, 0);
    Rst = 1'b0;

    do_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0);
    do_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    do_op("divu", MD_DIVU, 32'hFFFF_FFF9, 32'd2, 0, 0);
    do_op("divz", MD_DIVU, 32'd10, 32'd0, 0, 0);
    do_op("multu_clr", MD_MULTU, 32'd7, 32'd9, 0, 0);
    do_op("div_min", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);

    do_we(1'b0, 32'hFFFF_FFFF);
    do_we(1'b1, 32'h0);
    do_op("maddu", MD_MADDU, 32'd1, 32'd1, 0, 0);
    do_we(1'b1, 32'h0);
    do_we(1'b0, 32'h0);
    do_op("msub", MD_MSUB, 32'd1, 32'd1, 0, 0);

    do_we(1'b1, 32'hA5A5_0001);
    do_we(1'b0, 32'h5A5A_0002);
    @(negedge Clk);
    Start = 1'b1;
    Op = MD_DIVU;
    D1 = 32'd100;
    D2 = 32'd7;
    mdz = 1'b0;
    @(negedge Clk);
    Op = MD_MULTU;
    D1 = 32'd3;
    D2 = 32'd3;
    chk("cancel_busy_start", Busy, 1);
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Cancel = 1'b1;
    chk("cancel_busy_hold", Busy, 1);
    @(negedge Clk);
    Cancel = 1'b0;
    chk("cancel_busy_drop", Busy, 0);
    repeat (40) @(negedge Clk);
    chk("cancel_hi", HI, mh);
    chk("cancel_lo", LO, ml);
    chk("cancel_idle", Busy, 0);

    @(negedge Clk);
    Start = 1'b1;
    Cancel = 1'b1;
    Op = MD_MULTU;
    @(negedge Clk);
    Start = 1'b0;
    Cancel = 1'b0;
    chk("cancel_suppress", Busy, 0);

    do_we(1'b1, 32'h0000_1234);
    do_we(1'b0, 32'h0000_5678);
    @(negedge Clk);
    Start = 1'b1;
    Op = MD_MULTU;
    D1 = 32'd5;
    D2 = 32'd6;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(posedge Clk);
    #1 Rst = 1'b1;
    #1;
    chk("arst_hi", HI, 0);
    chk("arst_lo", LO, 0);
    chk("arst_busy", Busy, 0);
    mh = '0;
    ml = '0;
    mdz = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    repeat (10) @(negedge Clk);
    chk("arst_no_commit", LO, 0);
    do_we(1'b1, 32'hCAFE_0001);

    repeat (60) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = '0;
        1: begin a = 32'h8000_0000; b = '1; end
        2: begin
          a = 32'($urandom_range(0, 255));
          b = 32'($urandom_range(1, 15));
        end
        3: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      do_op("rnd", op, a, b, ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge Clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
